// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction, data) sharing one memory port.
//   clk, reset (async, active-high)
//   instr_m_*  : read-only instruction requester (addr/access in, ack/data out)
//   data_m_*   : read/write data requester (addr/data/access/wr_en/bytesel in, ack/data out)
//   q_m_*      : shared memory port (request out, ack/data in)
//   q_b        : high while the data requester owns the port
//   MEM_ARB_FAIR_EN : when defined, simultaneous requests alternate between requesters;
//                     otherwise data always wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in,
  output logic        q_b
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t state, state_nxt;
  logic pick_d;
`ifdef MEM_ARB_FAIR_EN
  // last_grant: 1 = data was served last, 0 = instruction (reset value)
  logic last_grant;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= 1'b0;
    else if (state == IDLE && state_nxt != IDLE) last_grant <= (state_nxt == GRANT_D);
  assign pick_d = data_m_access & (~instr_m_access | ~last_grant);
`else
  assign pick_d = data_m_access;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt       = state == IDLE ? (pick_d ? GRANT_D : instr_m_access ? GRANT_I : IDLE)
                                    : (q_m_ack ? IDLE : state);
    q_m_access      = state != IDLE;
    q_b             = state == GRANT_D;
    q_m_addr        = state == GRANT_D ? data_m_addr : state == GRANT_I ? instr_m_addr : 19'd0;
    q_m_data_out    = state == GRANT_D ? data_m_data_out : 16'd0;
    q_m_wr_en       = state == GRANT_D && data_m_wr_en;
    q_m_bytesel     = state == GRANT_D ? data_m_bytesel : state == GRANT_I ? 2'b11 : 2'b00;
    instr_m_ack     = state == GRANT_I && q_m_ack;
    data_m_ack      = state == GRANT_D && q_m_ack;
    instr_m_data_in = q_m_data_in;
    data_m_data_in  = q_m_data_in;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a per-cycle reference model.
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic [19:1] instr_m_addr = '0, data_m_addr = '0, q_m_addr;
  logic        instr_m_access = 1'b0, data_m_access = 1'b0, data_m_wr_en = 1'b0;
  logic [15:0] data_m_data_out = '0, q_m_data_in = '0, q_m_data_out, instr_m_data_in, data_m_data_in;
  logic [1:0]  data_m_bytesel = '0, q_m_bytesel;
  logic        instr_m_ack, data_m_ack, q_m_access, q_m_wr_en, q_b, q_m_ack = 1'b0;
  int checks = 0, errors = 0;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
  localparam logic [3:0] EXP_ORDER = 4'b0101;
`else
  localparam bit FAIR = 1'b0;
  localparam logic [3:0] EXP_ORDER = 4'b1111;
`endif

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access), .instr_m_ack(instr_m_ack),
    .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out), .data_m_access(data_m_access),
    .data_m_wr_en(data_m_wr_en), .data_m_bytesel(data_m_bytesel), .data_m_ack(data_m_ack),
    .data_m_data_in(data_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in), .q_b(q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = instruction, 2 = data; log holds 1 for each data grant.
  int m_owner = 0;
  bit m_last_d = 1'b0;
  bit grant_log[$];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= 0;
      m_last_d <= 1'b0;
    end else if (m_owner == 0) begin
      if (data_m_access && instr_m_access) begin
        m_owner <= (FAIR && m_last_d) ? 1 : 2;
        m_last_d <= !(FAIR && m_last_d);
        grant_log.push_back(!(FAIR && m_last_d));
      end else if (data_m_access || instr_m_access) begin
        m_owner <= data_m_access ? 2 : 1;
        m_last_d <= data_m_access;
        grant_log.push_back(data_m_access);
      end
    end else if (q_m_ack) m_owner <= 0;
  end

  always @(negedge clk) begin
    chk("cyc_access", {31'd0, q_m_access}, {31'd0, m_owner != 0});
    chk("cyc_q_b", {31'd0, q_b}, {31'd0, m_owner == 2});
    chk("cyc_addr", {13'd0, q_m_addr}, m_owner == 2 ? {13'd0, data_m_addr} : m_owner == 1 ? {13'd0, instr_m_addr} : 32'd0);
    chk("cyc_dout", {16'd0, q_m_data_out}, m_owner == 2 ? {16'd0, data_m_data_out} : 32'd0);
    chk("cyc_wr_en", {31'd0, q_m_wr_en}, {31'd0, m_owner == 2 && data_m_wr_en});
    chk("cyc_bytesel", {30'd0, q_m_bytesel}, m_owner == 2 ? {30'd0, data_m_bytesel} : m_owner == 1 ? 32'd3 : 32'd0);
    chk("cyc_instr_ack", {31'd0, instr_m_ack}, {31'd0, m_owner == 1 && q_m_ack});
    chk("cyc_data_ack", {31'd0, data_m_ack}, {31'd0, m_owner == 2 && q_m_ack});
    chk("cyc_instr_din", {16'd0, instr_m_data_in}, {16'd0, q_m_data_in});
    chk("cyc_data_din", {16'd0, data_m_data_in}, {16'd0, q_m_data_in});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!q_m_access && n < 8) begin
      tick();
      n++;
    end
    chk(name, {31'd0, q_m_access}, 32'd1);
  endtask

  logic [3:0] dut_order;
  logic [3:0] model_order;
  int log_start;

  initial begin
    repeat (2) tick();
    chk("rst_access", {31'd0, q_m_access}, 32'd0);
    chk("rst_q_b", {31'd0, q_b}, 32'd0);
    chk("rst_bytesel", {30'd0, q_m_bytesel}, 32'd0);
    reset = 1'b0;
    // instruction-only read, ack on the second grant cycle
    instr_m_addr = 19'h12345;
    instr_m_access = 1'b1;
    #1 chk("t1_idle_before", {31'd0, q_m_access}, 32'd0);
    tick();
    chk("t1_access", {31'd0, q_m_access}, 32'd1);
    chk("t1_addr", {13'd0, q_m_addr}, 32'h12345);
    chk("t1_bytesel", {30'd0, q_m_bytesel}, 32'd3);
    chk("t1_wr_en", {31'd0, q_m_wr_en}, 32'd0);
    tick();
    q_m_ack = 1'b1;
    q_m_data_in = 16'hBEEF;
    instr_m_access = 1'b0;
    #1;
    chk("t1_instr_ack", {31'd0, instr_m_ack}, 32'd1);
    chk("t1_instr_din", {16'd0, instr_m_data_in}, 32'hBEEF);
    chk("t1_data_ack", {31'd0, data_m_ack}, 32'd0);
    tick();
    q_m_ack = 1'b0;
    #1;
    chk("t1_released", {31'd0, q_m_access}, 32'd0);
    chk("t1_ack_pulse", {31'd0, instr_m_ack}, 32'd0);
    // data write
    data_m_addr = 19'h00010;
    data_m_data_out = 16'hA55A;
    data_m_bytesel = 2'b01;
    data_m_wr_en = 1'b1;
    data_m_access = 1'b1;
    tick();
    chk("t2_addr", {13'd0, q_m_addr}, 32'h10);
    chk("t2_dout", {16'd0, q_m_data_out}, 32'hA55A);
    chk("t2_bytesel", {30'd0, q_m_bytesel}, 32'd1);
    chk("t2_wr_en", {31'd0, q_m_wr_en}, 32'd1);
    chk("t2_q_b", {31'd0, q_b}, 32'd1);
    tick();
    chk("t2_q_b_hold", {31'd0, q_b}, 32'd1);
    q_m_ack = 1'b1;
    data_m_access = 1'b0;
    #1;
    chk("t2_data_ack", {31'd0, data_m_ack}, 32'd1);
    chk("t2_instr_ack", {31'd0, instr_m_ack}, 32'd0);
    tick();
    q_m_ack = 1'b0;
    #1;
    chk("t2_idle_q_b", {31'd0, q_b}, 32'd0);
    chk("t2_idle_access", {31'd0, q_m_access}, 32'd0);
    data_m_wr_en = 1'b0;
    // simultaneous continuous requests from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    log_start = grant_log.size();
    instr_m_addr = 19'h00111;
    data_m_addr = 19'h00222;
    instr_m_access = 1'b1;
    data_m_access = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t3_grant");
      dut_order[k] = q_b;
      q_m_ack = 1'b1;
      tick();
      q_m_ack = 1'b0;
      if (k == 3) begin
        instr_m_access = 1'b0;
        data_m_access = 1'b0;
      end
      #1 chk("t3_gap", {31'd0, q_m_access}, 32'd0);
      tick();
      if (k < 3) chk("t3_b2b", {31'd0, q_m_access}, 32'd1);
    end
    for (int k = 0; k < 4; k++) model_order[k] = (grant_log.size() > log_start + k) ? grant_log[log_start + k] : 1'bx;
    chk("t3_dut_order", {28'd0, dut_order}, {28'd0, EXP_ORDER});
    chk("t3_model_order", {28'd0, model_order}, {28'd0, EXP_ORDER});
    // reset during a data grant
    data_m_access = 1'b1;
    tick();
    chk("t4_q_b", {31'd0, q_b}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t4_rst_access", {31'd0, q_m_access}, 32'd0);
    chk("t4_rst_q_b", {31'd0, q_b}, 32'd0);
    data_m_access = 1'b0;
    instr_m_access = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t4_grant_i", {31'd0, q_m_access}, 32'd1);
    chk("t4_grant_i_q_b", {31'd0, q_b}, 32'd0);
    chk("t4_grant_i_bs", {30'd0, q_m_bytesel}, 32'd3);
    q_m_ack = 1'b1;
    instr_m_access = 1'b0;
    tick();
    q_m_ack = 1'b0;
    // spurious ack in IDLE, then data access dropped mid-grant
    q_m_ack = 1'b1;
    #1;
    chk("t5_spur_iack", {31'd0, instr_m_ack}, 32'd0);
    chk("t5_spur_dack", {31'd0, data_m_ack}, 32'd0);
    tick();
    chk("t5_spur_idle", {31'd0, q_m_access}, 32'd0);
    q_m_ack = 1'b0;
    data_m_addr = 19'h7FFFF;
    data_m_access = 1'b1;
    tick();
    chk("t5_addr_max", {13'd0, q_m_addr}, 32'h7FFFF);
    data_m_access = 1'b0;
    repeat (2) tick();
    chk("t5_hold_access", {31'd0, q_m_access}, 32'd1);
    chk("t5_hold_q_b", {31'd0, q_b}, 32'd1);
    chk("t5_hold_dack", {31'd0, data_m_ack}, 32'd0);
    q_m_ack = 1'b1;
    #1 chk("t5_real_dack", {31'd0, data_m_ack}, 32'd1);
    tick();
    q_m_ack = 1'b0;
    #1 chk("t5_final_idle", {31'd0, q_m_access}, 32'd0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
